// File: rtl/uart_tx_arbiter_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit arbiter.
//   arb_state_t : arbiter FSM states
//   BYTE_W      : width of one UART byte
//   clog2       : ceiling log2, minimum 1, usable in constant expressions
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and serializer-side signals of the
// UART transmit arbiter.
//   req_valid/req_data/req_last/req_ready : per-requester byte streams
//   tx_data/tx_start/tx_busy              : byte interface to uart_tx
//   grant_id/frame_active                 : arbitration status
// slave modport = arbiter view, master modport = requesters + serializer.
interface uart_tx_arbiter_if import uart_pkg::*; #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [BYTE_W-1:0]         tx_data;
  logic                      tx_start;
  logic                      tx_busy;
  logic [ID_W-1:0]           grant_id;
  logic                      frame_active;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_start, grant_id, frame_active
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_start, grant_id, frame_active
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
//   req     : request vector
//   ptr     : highest-priority index
//   idx     : first set request at or after ptr, wrapping around
//   any_req : at least one request set
module rr_pick import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    idx,
  output logic               any_req
);
  logic [ID_W-1:0]    pos [NUM_REQ];
  logic [NUM_REQ-1:0] hit;
  // sel[k] holds the winner among offsets k..NUM_REQ-1; offset 0 is ptr itself.
  logic [ID_W-1:0]    sel [NUM_REQ+1];

  assign sel[NUM_REQ] = '0;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [ID_W:0] sum;
    assign sum = {1'b0, ptr} + (ID_W+1)'(gi);
    assign pos[gi] = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                 : ID_W'(sum);
    assign hit[gi] = req[pos[gi]];
    assign sel[gi] = hit[gi] ? pos[gi] : sel[gi+1];
  end

  assign idx     = sel[0];
  assign any_req = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer between NUM_REQ byte
// streams. Grants are round-robin and held for a whole frame (req_last),
// force-released after MAX_FRAME bytes or IDLE_TIMEOUT idle cycles.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : uart_tx_arbiter_if.slave (requester streams, serializer, status)
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_FRAME    = 16,
  parameter int IDLE_TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_W  = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_FRAME + 1);
  localparam int TO_W  = clog2(IDLE_TIMEOUT + 1);

  arb_state_t        state_reg, state_next;
  logic [ID_W-1:0]   grant_id_reg, grant_id_next;
  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic              frame_active_reg, frame_active_next;
  logic [CNT_W-1:0]  byte_cnt_reg, byte_cnt_next;
  logic              last_flag_reg, last_flag_next;
  logic [TO_W-1:0]   timeout_cnt_reg, timeout_cnt_next;
  logic [1:0]        guard_cnt_reg, guard_cnt_next;
  logic [BYTE_W-1:0] tx_data_reg, tx_data_next;
  logic              tx_start_reg, tx_start_next;

  logic [BYTE_W-1:0]  req_byte [NUM_REQ];
  logic [NUM_REQ-1:0] ready_vec;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               g_valid;
  logic               do_release;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign req_byte[gi] = bus.req_data[BYTE_W*gi +: BYTE_W];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_reg),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  assign g_valid = bus.req_valid[grant_id_reg];

  always_comb begin
    state_next        = state_reg;
    grant_id_next     = grant_id_reg;
    rr_ptr_next       = rr_ptr_reg;
    frame_active_next = frame_active_reg;
    byte_cnt_next     = byte_cnt_reg;
    last_flag_next    = last_flag_reg;
    timeout_cnt_next  = timeout_cnt_reg;
    guard_cnt_next    = guard_cnt_reg;
    tx_data_next      = tx_data_reg;
    tx_start_next     = 1'b0;
    ready_vec         = '0;
    do_release        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next        = SEND;
          grant_id_next     = pick_idx;
          frame_active_next = 1'b1;
          timeout_cnt_next  = '0;
        end
      end
      SEND: begin
        if (g_valid) begin
          if (!bus.tx_busy) begin
            ready_vec[grant_id_reg] = 1'b1;
            tx_data_next   = req_byte[grant_id_reg];
            tx_start_next  = 1'b1;
            if (byte_cnt_reg != CNT_W'(MAX_FRAME))
              byte_cnt_next = byte_cnt_reg + CNT_W'(1);
            last_flag_next = bus.req_last[grant_id_reg] ||
                             (byte_cnt_reg == CNT_W'(MAX_FRAME - 1));
            guard_cnt_next = '0;
            state_next     = WAIT_BUSY;
          end
        end else if (timeout_cnt_reg == TO_W'(IDLE_TIMEOUT - 1)) begin
          // This idle cycle is the IDLE_TIMEOUT-th one: revoke the grant now.
          do_release = 1'b1;
        end else begin
          timeout_cnt_next = timeout_cnt_reg + TO_W'(1);
        end
      end
      WAIT_BUSY: begin
        // Busy is sampled on the 3 cycles after tx_start; if the serializer
        // never reacts the byte is considered sent so the frame cannot stall.
        if (bus.tx_busy || guard_cnt_reg == 2'd2) state_next = WAIT_DONE;
        else guard_cnt_next = guard_cnt_reg + 2'd1;
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_flag_reg) begin
            do_release = 1'b1;
          end else begin
            state_next       = SEND;
            timeout_cnt_next = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (do_release) begin
      state_next        = IDLE;
      frame_active_next = 1'b0;
      rr_ptr_next       = (grant_id_reg == ID_W'(NUM_REQ - 1)) ? '0
                                                                : grant_id_reg + ID_W'(1);
      byte_cnt_next     = '0;
      timeout_cnt_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      grant_id_reg     <= '0;
      rr_ptr_reg       <= '0;
      frame_active_reg <= 1'b0;
      byte_cnt_reg     <= '0;
      last_flag_reg    <= 1'b0;
      timeout_cnt_reg  <= '0;
      guard_cnt_reg    <= '0;
      tx_data_reg      <= '0;
      tx_start_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      grant_id_reg     <= grant_id_next;
      rr_ptr_reg       <= rr_ptr_next;
      frame_active_reg <= frame_active_next;
      byte_cnt_reg     <= byte_cnt_next;
      last_flag_reg    <= last_flag_next;
      timeout_cnt_reg  <= timeout_cnt_next;
      guard_cnt_reg    <= guard_cnt_next;
      tx_data_reg      <= tx_data_next;
      tx_start_reg     <= tx_start_next;
    end
  end

  assign bus.req_ready    = ready_vec;
  assign bus.tx_data      = tx_data_reg;
  assign bus.tx_start     = tx_start_reg;
  assign bus.grant_id     = grant_id_reg;
  assign bus.frame_active = frame_active_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter. Requester
// models feed byte queues, a serializer model generates tx_busy, and a
// monitor pops the expected (grant, byte) pair on every tx_start.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int MAX_FRAME    = 16;
  localparam int IDLE_TIMEOUT = 1023;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_FRAME(MAX_FRAME), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q [$];
  logic [8:0] rq [NUM_REQ][$];
  int n_checks  = 0;
  int n_fail    = 0;
  int start_cnt = 0;
  int busy_len  = 20;
  bit busy_en   = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_req(input int r, input logic [7:0] data, input bit last);
    rq[r].push_back({last, data});
  endtask

  task automatic push_exp(input int id, input logic [7:0] data);
    exp_t e;
    e.id   = 8'(id);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_start_pulse(input int budget);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.tx_start && c < budget);
    if (!bus.tx_start) check("wait_tx_start", bus.tx_start, 1);
  endtask

  task automatic wait_busy(input logic level, input int budget);
    int c = 0;
    while (bus.tx_busy !== level && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (bus.tx_busy !== level) check("wait_tx_busy", bus.tx_busy, level);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || bus.frame_active || bus.tx_busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({name, "_frame_done"}, bus.frame_active, 0);
    check({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // Requester models: accept seen at negedge, pop and redrive after posedge.
  initial begin
    logic [NUM_REQ-1:0]        acc, v, l;
    logic [BYTE_W*NUM_REQ-1:0] d;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          v[i]            = 1'b1;
          d[8*i +: 8]     = rq[i][0][7:0];
          l[i]            = rq[i][0][8];
        end
      end
      bus.req_valid = v;
      bus.req_data  = d;
      bus.req_last  = l;
    end
  end

  // Serializer model: busy rises one cycle after tx_start, lasts busy_len cycles.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start && busy_en) begin
        @(posedge clk);
        #1 bus.tx_busy = 1'b1;
        repeat (busy_len - 1) @(posedge clk);
        #1 bus.tx_busy = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.req_ready != '0) check("ready_onehot", 32'($onehot(bus.req_ready)), 1);
      if (bus.tx_start) begin
        start_cnt++;
        check("start_while_busy", bus.tx_busy, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_start", bus.tx_start, 0);
        end else begin
          e = exp_q.pop_front();
          $display("tx #%0d grant=%0d data=0x%02h (want grant=%0d data=0x%02h) t=%0t",
                   start_cnt, bus.grant_id, bus.tx_data, e.id, e.data, $time);
          check("tx_data", bus.tx_data, e.data);
          check("grant_id", bus.grant_id, e.id);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int s;

    // Reset state.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_frame_active", bus.frame_active, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // T1: requester 0 sends 41,42,43 (last); first start 3 negedges after push.
    busy_len = 20;
    push_req(0, 8'h41, 0); push_req(0, 8'h42, 0); push_req(0, 8'h43, 1);
    push_exp(0, 8'h41); push_exp(0, 8'h42); push_exp(0, 8'h43);
    repeat (2) @(negedge clk);
    check("t1_no_early_start", bus.tx_start, 0);
    @(negedge clk);
    check("t1_first_start", bus.tx_start, 1);
    wait_start_pulse(100);
    wait_start_pulse(100);
    wait_busy(1'b1, 10);
    wait_busy(1'b0, 50);
    check("t1_active_at_busy_drop", bus.frame_active, 1);
    @(negedge clk);
    check("t1_released", bus.frame_active, 0);
    wait_drain("t1", 50);

    // T2: requesters 1 and 2 together; 1 goes first, frames do not interleave.
    busy_len = 6;
    push_req(1, 8'hA1, 0); push_req(1, 8'hA2, 1);
    push_req(2, 8'hB1, 0); push_req(2, 8'hB2, 1);
    push_exp(1, 8'hA1); push_exp(1, 8'hA2); push_exp(2, 8'hB1); push_exp(2, 8'hB2);
    wait_drain("t2", 500);

    // T3: requester 3 streams 20 bytes, force release after 16; requester 0 in between.
    busy_len = 4;
    for (int k = 0; k < 20; k++) push_req(3, 8'(8'hC0 + k), k == 19);
    push_req(0, 8'h5A, 1);
    for (int k = 0; k < 16; k++) push_exp(3, 8'(8'hC0 + k));
    push_exp(0, 8'h5A);
    for (int k = 16; k < 20; k++) push_exp(3, 8'(8'hC0 + k));
    wait_drain("t3", 2000);

    // T4: requester 0 sends one byte then goes silent; requester 2 pending.
    busy_len = 6;
    push_req(0, 8'hE0, 0);
    push_req(2, 8'hF0, 1);
    push_exp(0, 8'hE0); push_exp(2, 8'hF0);
    wait_start_pulse(50);
    wait_busy(1'b1, 10);
    wait_busy(1'b0, 50);
    repeat (IDLE_TIMEOUT) @(negedge clk);
    check("t4_held_before_timeout", bus.frame_active, 1);
    check("t4_grant_before_timeout", bus.grant_id, 0);
    @(negedge clk);
    check("t4_revoked_at_timeout", bus.frame_active, 0);
    @(negedge clk);
    check("t4_next_active", bus.frame_active, 1);
    check("t4_next_grant", bus.grant_id, 2);
    wait_drain("t4", 200);

    // T5: reset during WAIT_DONE of byte 2 of a 3-byte frame.
    busy_len = 20;
    push_req(1, 8'h60, 0); push_req(1, 8'h61, 0); push_req(1, 8'h62, 1);
    push_exp(1, 8'h60); push_exp(1, 8'h61);
    wait_start_pulse(50);
    wait_start_pulse(100);
    wait_busy(1'b1, 10);
    repeat (3) @(negedge clk);
    check("t5_active_before_rst", bus.frame_active, 1);
    rst = 1'b0;
    #1;
    check("t5_rst_tx_start", bus.tx_start, 0);
    check("t5_rst_tx_data", bus.tx_data, 0);
    check("t5_rst_req_ready", bus.req_ready, 0);
    check("t5_rst_grant_id", bus.grant_id, 0);
    check("t5_rst_frame_active", bus.frame_active, 0);
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    s = start_cnt;
    repeat (100) @(negedge clk);
    check("t5_quiet_after_rst", start_cnt - s, 0);
    check("t5_idle_after_rst", bus.frame_active, 0);

    // T6: serializer never raises busy; the guard advances after 3 cycles.
    wait_busy(1'b0, 50);
    busy_en = 1'b0;
    push_req(2, 8'h70, 0); push_req(2, 8'h71, 1);
    push_exp(2, 8'h70); push_exp(2, 8'h71);
    wait_start_pulse(50);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.tx_start && c < 20);
    check("t6_guard_gap", c, 5);
    wait_drain("t6", 50);
    busy_en = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
